// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential issue controller for a combinational 16-bit ALU.
//
// Tagged commands arrive on a valid/ready stream and are buffered in a
// DEPTH-entry FIFO. For each command the block drives registered S/A/B to
// the ALU and holds them for SETTLE_CYC cycles. It then captures Z and
// returns it with the command tag on a valid/ready response stream.
// A divide (op 3) with B == 0 is never issued. Instead it is answered
// locally with data 32'hFFFF_FFFF and rsp_err = 1.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready = FIFO not full)
//   cmd_op/a/b/tag        command fields
//   alu_s/alu_a/alu_b     registered ALU inputs; hold the last issued values
//   alu_z                 ALU result
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/tag/err      captured result, command tag, divide-by-zero flag
//   stat_cmds/stat_errs   saturating handshake counters; present only when
//                         the ALU_STATS_EN macro is defined
//
// Optional feature macro: ALU_STATS_EN
module alu_issue_ctrl #(
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_s,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    input  logic [31:0]      alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
`ifdef ALU_STATS_EN
    ,
    output logic [15:0]      stat_cmds,
    output logic [15:0]      stat_errs
`endif
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int ENT_W  = TAG_W + 36;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [ENT_W-1:0]  fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_n;
    logic              cmd_ready_r;
    logic              push_s;
    logic              pop_s;
    logic              fifo_empty_s;

    // FIFO head, unpacked as {op, a, b, tag}
    logic [ENT_W-1:0]  head_s;
    logic [3:0]        head_op_s;
    logic [15:0]       head_a_s;
    logic [15:0]       head_b_s;
    logic [TAG_W-1:0]  head_tag_s;
    logic              head_div0_s;

    // FSM and datapath registers with their next values
    state_t            state_r, state_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [3:0]        alu_s_r, alu_s_n;
    logic [15:0]       alu_a_r, alu_a_n;
    logic [15:0]       alu_b_r, alu_b_n;
    logic [TAG_W-1:0]  pend_tag_r, pend_tag_n;
    logic              rsp_valid_r, rsp_valid_n;
    logic [31:0]       rsp_data_r, rsp_data_n;
    logic [TAG_W-1:0]  rsp_tag_r, rsp_tag_n;
    logic              rsp_err_r, rsp_err_n;

    assign fifo_empty_s = (fill_r == FILL_W'(0));
    assign push_s       = cmd_valid && cmd_ready_r;
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign head_op_s    = head_s[TAG_W+35:TAG_W+32];
    assign head_a_s     = head_s[TAG_W+31:TAG_W+16];
    assign head_b_s     = head_s[TAG_W+15:TAG_W];
    assign head_tag_s   = head_s[TAG_W-1:0];
    assign head_div0_s  = (head_op_s == 4'd3) && (head_b_s == 16'd0);

    // Next FIFO fill level from this cycle's push and pop.
    always_comb begin
        fill_n = fill_r;
        case ({push_s, pop_s})
            2'b10:   fill_n = fill_r + FILL_W'(1);
            2'b01:   fill_n = fill_r - FILL_W'(1);
            default: fill_n = fill_r;
        endcase
    end

    // FIFO data write; entries need no reset because fill_r qualifies them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
        end
    end

    // FIFO pointers, fill level and registered ready.
    // Ready is computed from the next fill level. A pop while the FIFO is
    // full therefore reopens ready one cycle later, with no path from pop
    // to ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= PTR_W'(0);
            rd_ptr_r    <= PTR_W'(0);
            fill_r      <= FILL_W'(0);
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            fill_r      <= fill_n;
            cmd_ready_r <= (fill_n != FILL_W'(DEPTH));
        end
    end

    // Issue FSM next state, datapath loads and the FIFO pop decision.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        alu_s_n     = alu_s_r;
        alu_a_n     = alu_a_r;
        alu_b_n     = alu_b_r;
        pend_tag_n  = pend_tag_r;
        rsp_valid_n = rsp_valid_r;
        rsp_data_n  = rsp_data_r;
        rsp_tag_n   = rsp_tag_r;
        rsp_err_n   = rsp_err_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (head_div0_s) begin
                        // Trap locally; the ALU inputs keep their last values.
                        rsp_data_n  = 32'hFFFF_FFFF;
                        rsp_err_n   = 1'b1;
                        rsp_tag_n   = head_tag_s;
                        rsp_valid_n = 1'b1;
                        state_n     = ST_RESP;
                    end else begin
                        alu_s_n    = head_op_s;
                        alu_a_n    = head_a_s;
                        alu_b_n    = head_b_s;
                        pend_tag_n = head_tag_s;
                        cnt_n      = CNT_W'(SETTLE_CYC - 1);
                        state_n    = ST_SETTLE;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r != CNT_W'(0)) begin
                    cnt_n = cnt_r - CNT_W'(1);
                end else begin
                    rsp_data_n  = alu_z;
                    rsp_err_n   = 1'b0;
                    rsp_tag_n   = pend_tag_r;
                    rsp_valid_n = 1'b1;
                    state_n     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = ST_IDLE;
                end else begin
                    state_n = ST_RESP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state and datapath register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_W'(0);
            alu_s_r     <= 4'd0;
            alu_a_r     <= 16'd0;
            alu_b_r     <= 16'd0;
            pend_tag_r  <= TAG_W'(0);
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
            rsp_tag_r   <= TAG_W'(0);
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            alu_s_r     <= alu_s_n;
            alu_a_r     <= alu_a_n;
            alu_b_r     <= alu_b_n;
            pend_tag_r  <= pend_tag_n;
            rsp_valid_r <= rsp_valid_n;
            rsp_data_r  <= rsp_data_n;
            rsp_tag_r   <= rsp_tag_n;
            rsp_err_r   <= rsp_err_n;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign alu_s     = alu_s_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_tag   = rsp_tag_r;
    assign rsp_err   = rsp_err_r;

`ifdef ALU_STATS_EN
    logic [15:0] stat_cmds_r;
    logic [15:0] stat_errs_r;
    logic        rsp_hs_s;

    assign rsp_hs_s = rsp_valid_r && rsp_ready;

    // Saturating counters of response handshakes and trapped divides.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cmds_r <= 16'd0;
            stat_errs_r <= 16'd0;
        end else begin
            if (rsp_hs_s && (stat_cmds_r != 16'hFFFF)) begin
                stat_cmds_r <= stat_cmds_r + 16'd1;
            end
            if (rsp_hs_s && rsp_err_r && (stat_errs_r != 16'hFFFF)) begin
                stat_errs_r <= stat_errs_r + 16'd1;
            end
        end
    end

    assign stat_cmds = stat_cmds_r;
    assign stat_errs = stat_errs_r;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int DEPTH      = 4;
    localparam int SETTLE_CYC = 2;
    localparam int TAG_W      = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [15:0]      cmd_a;
    logic [15:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [3:0]       alu_s;
    logic [15:0]      alu_a;
    logic [15:0]      alu_b;
    logic [31:0]      alu_z;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
`ifdef ALU_STATS_EN
    logic [15:0]      stat_cmds;
    logic [15:0]      stat_errs;
`endif

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(DEPTH), .SETTLE_CYC(SETTLE_CYC), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
`ifdef ALU_STATS_EN
        , .stat_cmds(stat_cmds), .stat_errs(stat_errs)
`endif
    );

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t act_log[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rsp = 0;
    int   cyc = 0;

    // ALU behaviour: signed 16-bit arithmetic, sign-extended to 32 bits
    function automatic logic [31:0] alu_fn(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (s)
            4'd0:    return 32'(sa + sb);
            4'd1:    return 32'(sa - sb);
            4'd2:    return 32'(sa * sb);
            4'd3:    return (sb == 0) ? 32'd0 : 32'(sa / sb);
            default: return {~a, b ^ {12'd0, s}};
        endcase
    endfunction

    // Expected response for one command
    function automatic rsp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [TAG_W-1:0] tag);
        rsp_t r;
        r.tag = tag;
        if (op == 4'd3 && b == 16'd0) begin
            r.data = 32'hFFFF_FFFF;
            r.err  = 1'b1;
        end else begin
            r.data = alu_fn(op, a, b);
            r.err  = 1'b0;
        end
        return r;
    endfunction

    // The ALU model returns poison until its inputs have been stable for SETTLE_CYC cycles
    int          held = 0;
    logic [35:0] last_in = 36'd0;
    always @(negedge clk) begin
        if ({alu_s, alu_a, alu_b} != last_in) held <= 1;
        else if (held < 1000) held <= held + 1;
        last_in <= {alu_s, alu_a, alu_b};
    end
    assign alu_z = (held >= SETTLE_CYC) ? alu_fn(alu_s, alu_a, alu_b) : 32'hBAD0_BAD0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: checks every response cycle against the scoreboard
    logic prev_hold = 1'b0;
    rsp_t prev_rsp;
    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            chk("no_spurious_rsp", {31'd0, rsp_valid}, 32'd0);
        end else if (rsp_valid) begin
            chk("rsp_data", rsp_data, exp_q[0].data);
            chk("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
        end
        if (prev_hold) begin
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_data", rsp_data, prev_rsp.data);
            chk("hold_tag", 32'(rsp_tag), 32'(prev_rsp.tag));
            chk("hold_err", {31'd0, rsp_err}, {31'd0, prev_rsp.err});
        end
        if (rsp_valid && rsp_ready && !rst) begin
            act_log.push_back({rsp_data, rsp_tag, rsp_err});
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_rsp <= n_rsp + 1;
        end
        if (rst) exp_q.delete();
        prev_hold <= rsp_valid && !rsp_ready && !rst;
        prev_rsp  <= {rsp_data, rsp_tag, rsp_err};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command until accepted or max_wait cycles pass; acc = accept edge number
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [TAG_W-1:0] tag, input int max_wait, output int acc, output bit ok);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        ok = 1'b0;
        acc = -1;
        for (int i = 0; i < max_wait; i++) begin
            if (cmd_ready) begin
                exp_q.push_back(model(op, a, b, tag));
                acc = cyc + 1;
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int t, output bit ok);
        ok = 1'b0;
        t = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string nm, input int max);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < max) begin
            tick();
            i++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({nm, "_rsp_data"}, rsp_data, 32'd0);
        chk({nm, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
        chk({nm, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({nm, "_alu_s"}, 32'(alu_s), 32'd0);
        chk({nm, "_alu_a"}, 32'(alu_a), 32'd0);
        chk({nm, "_alu_b"}, 32'(alu_b), 32'd0);
        chk({nm, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        int  acc2;
        int  t;
        int  base;
        int  n_acc;
        int  rsp_before;
        bit  ok;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 16'd0; cmd_b = 16'd0;
        cmd_tag = '0; rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("init");

        // Add: valid SETTLE_CYC+1 edges after acceptance
        rsp_ready = 1'b1;
        send(4'd0, 16'd166, 16'd235, 4'd3, 10, acc, ok);
        chk("add_accept", {31'd0, ok}, 32'd1);
        wait_valid(20, t, ok);
        chk("add_valid_seen", {31'd0, ok}, 32'd1);
        chk("add_latency", t, acc + SETTLE_CYC + 1);
        chk("add_data", rsp_data, 32'h0000_0191);
        chk("add_tag", 32'(rsp_tag), 32'd3);
        chk("add_err", {31'd0, rsp_err}, 32'd0);
        tick();
        wait_drain("add_drain", 20);

        // Multiply then divide back to back: second issue 4 cycles after first
        base = act_log.size();
        send(4'd2, 16'd771, 16'hFFD4, 4'd1, 10, acc, ok);
        chk("mul_accept", {31'd0, ok}, 32'd1);
        send(4'd3, 16'd725, 16'd34, 4'd2, 10, acc2, ok);
        chk("div_accept", {31'd0, ok}, 32'd1);
        chk("b2b_accept_gap", acc2, acc + 1);
        chk("issue1_s", 32'(alu_s), 32'd2);
        chk("issue1_a", 32'(alu_a), 32'd771);
        tick(); tick(); tick();
        chk("issue1_hold_a", 32'(alu_a), 32'd771);
        tick();
        chk("issue2_s", 32'(alu_s), 32'd3);
        chk("issue2_a", 32'(alu_a), 32'd725);
        chk("issue2_b", 32'(alu_b), 32'd34);
        wait_drain("b2b_drain", 30);
        chk("b2b_count", act_log.size() - base, 32'd2);
        if (act_log.size() - base >= 2) begin
            chk("mul_data", act_log[base].data, 32'hFFFF_7B7C);
            chk("mul_tag", 32'(act_log[base].tag), 32'd1);
            chk("div_data", act_log[base+1].data, 32'h0000_0015);
            chk("div_tag", 32'(act_log[base+1].tag), 32'd2);
        end

        // Divide by zero: trapped, ALU inputs untouched
        send(4'd3, 16'd99, 16'd0, 4'd7, 10, acc, ok);
        chk("dz_accept", {31'd0, ok}, 32'd1);
        wait_valid(20, t, ok);
        chk("dz_valid_seen", {31'd0, ok}, 32'd1);
        chk("dz_latency", t, acc + 1);
        chk("dz_data", rsp_data, 32'hFFFF_FFFF);
        chk("dz_err", {31'd0, rsp_err}, 32'd1);
        chk("dz_tag", 32'(rsp_tag), 32'd7);
        chk("dz_alu_s", 32'(alu_s), 32'd3);
        chk("dz_alu_a", 32'(alu_a), 32'd725);
        chk("dz_alu_b", 32'(alu_b), 32'd34);
        tick();
        wait_drain("dz_drain", 20);

        // Full FIFO under backpressure
        rsp_ready = 1'b0;
        base = act_log.size();
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(4'd8, 16'h00FF, 16'(i), TAG_W'(i), 3, acc, ok);
            if (ok) n_acc++;
        end
        chk("full_accepted", n_acc, 32'd5);
        chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("full_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("full_hold_tag", 32'(rsp_tag), 32'd0);
            chk("full_hold_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        wait_drain("full_drain", 100);
        chk("full_count", act_log.size() - base, 32'd5);
        if (act_log.size() - base >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("full_order_tag", 32'(act_log[base+i].tag), i);
            end
        end

        // Reset while in SETTLE with two commands queued
        rsp_ready = 1'b1;
        send(4'd0, 16'd1, 16'd2, 4'd10, 10, acc, ok);
        chk("rst_accept0", {31'd0, ok}, 32'd1);
        send(4'd0, 16'd3, 16'd4, 4'd11, 10, acc, ok);
        chk("rst_accept1", {31'd0, ok}, 32'd1);
        send(4'd0, 16'd5, 16'd6, 4'd12, 10, acc, ok);
        chk("rst_accept2", {31'd0, ok}, 32'd1);
        rsp_before = n_rsp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        for (int i = 0; i < 20; i++) tick();
        chk("midrst_no_rsp", n_rsp, rsp_before);

`ifdef ALU_STATS_EN
        // Statistics: 3 normal and 2 trapped commands since reset
        chk("stat_cmds_reset", 32'(stat_cmds), 32'd0);
        send(4'd0, 16'd10, 16'd20, 4'd1, 10, acc, ok);
        send(4'd3, 16'd10, 16'd0, 4'd2, 10, acc, ok);
        send(4'd1, 16'd50, 16'd20, 4'd3, 10, acc, ok);
        send(4'd3, 16'd77, 16'd0, 4'd4, 10, acc, ok);
        send(4'd2, 16'd6, 16'd7, 4'd5, 10, acc, ok);
        wait_drain("stat_drain", 100);
        tick();
        chk("stat_cmds", 32'(stat_cmds), 32'd5);
        chk("stat_errs", 32'(stat_errs), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
